// File: rtl/spi_slave_fifo.sv
`timescale 1ns/1ps
// spi_slave_fifo
//
// Fabric-side SPI slave (mode 0, MSB first). The external SPI pins are
// oversampled in the FAB_CCC_GL0 domain. Received bytes land in a
// first-word-fall-through RX FIFO. Transmit bytes come from a one-deep
// holding register that is consumed at each byte boundary.
//
// Ports
//   FAB_CCC_GL0, FAB_RESET      : the only clock; synchronous active-high reset
//   s_sck, s_mosi, s_ss         : asynchronous SPI inputs from the master (SS active low)
//   s_miso                      : SPI data to the master (1 when no frame is active)
//   rx_data, rx_valid, rx_ready : FIFO head; a pop occurs on rx_valid & rx_ready
//   rx_count                    : FIFO occupancy
//   rx_overflow, rx_overflow_clr: sticky drop flag and its clear (set wins)
//   tx_data, tx_load, tx_ready  : holding-register load strobe and empty flag
//   frame_active                : slave is inside a frame
//   frame_err                   : one-cycle pulse, SS released mid-byte
//   dbg_state                   : FSM state (0 = IDLE, 1 = ACTIVE)
//
// Handshakes: rx side is strict valid/ready. rx_data is stable while
// rx_valid is high and no pop occurs; a pop happens on any cycle with
// rx_valid & rx_ready. On the tx side, tx_load is honoured only while
// tx_ready is high; a load while tx_ready is low is dropped.
module spi_slave_fifo #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       FAB_CCC_GL0,
  input  logic                       FAB_RESET,
  input  logic                       s_sck,
  input  logic                       s_mosi,
  input  logic                       s_ss,
  output logic                       s_miso,
  output logic [7:0]                 rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [$clog2(DEPTH+1)-1:0] rx_count,
  output logic                       rx_overflow,
  input  logic                       rx_overflow_clr,
  input  logic [7:0]                 tx_data,
  input  logic                       tx_load,
  output logic                       tx_ready,
  output logic                       frame_active,
  output logic                       frame_err,
  output logic                       dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t state, state_nxt;

  // synchronizers, edge flops, and flush tracking
  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ss_sync, flush;
  logic                   sck_q, ss_q, armed;
  logic                   sck_s, mosi_s, ss_s;
  logic                   sck_rise, sck_fall, ss_fall, ss_rise;

  // datapath
  logic [2:0]  bitcnt;
  logic [6:0]  rx_shift;
  logic [7:0]  tx_shift, tx_hold;
  logic        pending;
  logic        reload, tx_shift_en, push;
  logic [7:0]  push_byte;

  // fifo
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        full, pop, wr_en;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign ss_rise  = ss_s & ~ss_q;
  // A frame may only open after SS has been seen high with real pin data,
  // so an SS already low when reset releases does not start a frame.
  assign ss_fall  = armed & ss_q & ~ss_s;

  always_ff @(posedge FAB_CCC_GL0) begin
    if (FAB_RESET) begin
      sck_sync  <= '1;
      mosi_sync <= '1;
      ss_sync   <= '1;
      sck_q     <= 1'b1;
      ss_q      <= 1'b1;
      flush     <= '0;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], s_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], s_mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], s_ss};
      sck_q     <= sck_s;
      ss_q      <= ss_s;
      // flush[MSB] goes high once the last sync stage holds sampled pin data
      flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
      armed     <= armed | (flush[SYNC_STAGES-1] & ss_s);
    end
  end

  // FSM
  always_ff @(posedge FAB_CCC_GL0) begin
    if (FAB_RESET) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    reload      = 1'b0;
    tx_shift_en = 1'b0;
    push        = 1'b0;
    push_byte   = {rx_shift, mosi_s};
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt = ACTIVE;
          reload    = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_nxt = IDLE;
        end else begin
          push        = sck_rise & (bitcnt == 3'd7);
          reload      = sck_fall & (bitcnt == 3'd0);
          tx_shift_en = sck_fall & (bitcnt != 3'd0);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // shift registers, bit counter, tx holding register
  always_ff @(posedge FAB_CCC_GL0) begin
    if (FAB_RESET) begin
      bitcnt    <= 3'd0;
      rx_shift  <= 7'd0;
      tx_shift  <= 8'hFF;
      tx_hold   <= 8'h00;
      pending   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (state == IDLE) begin
        if (ss_fall) bitcnt <= 3'd0;
      end else if (ss_rise) begin
        // partial byte is simply abandoned; rx_shift is fully refilled next byte
        bitcnt    <= 3'd0;
        frame_err <= (bitcnt != 3'd0);
      end else if (sck_rise) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
        bitcnt   <= bitcnt + 3'd1;
      end

      if (reload) begin
        if (pending) begin
          tx_shift <= tx_hold;
          pending  <= 1'b0;
        end else begin
          tx_shift <= 8'hFF;
        end
      end else if (tx_shift_en) begin
        tx_shift <= {tx_shift[6:0], 1'b1};
      end

      // load is only accepted with pending low, reload only clears it when
      // high, so the two never fight over pending in the same cycle
      if (tx_load && !pending) begin
        tx_hold <= tx_data;
        pending <= 1'b1;
      end
    end
  end

  // RX FIFO
  assign rx_count = CW'(wptr - rptr);
  assign full     = (rx_count == CW'(DEPTH));
  assign rx_valid = (rx_count != '0);
  assign pop      = rx_valid & rx_ready;
  // a pop in the same cycle frees the head slot, so a full FIFO still accepts
  assign wr_en    = push & (~full | pop);
  assign rx_data  = rx_valid ? mem[rptr[AW-1:0]] : 8'h00;

  always_ff @(posedge FAB_CCC_GL0) begin
    if (wr_en) mem[wptr[AW-1:0]] <= push_byte;
  end

  always_ff @(posedge FAB_CCC_GL0) begin
    if (FAB_RESET) begin
      wptr        <= '0;
      rptr        <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      if (push && full && !pop) rx_overflow <= 1'b1;
      else if (rx_overflow_clr) rx_overflow <= 1'b0;
    end
  end

  assign s_miso       = (state == ACTIVE) ? tx_shift[7] : 1'b1;
  assign tx_ready     = ~pending;
  assign frame_active = (state == ACTIVE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_spi_slave_fifo.sv
`timescale 1ns/1ps
module tb_spi_slave_fifo;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int HALF  = 6;   // fabric cycles per SCK phase

  localparam int M_NONE = 0;
  localparam int M_LAT  = 1;  // check rx_valid latency on the last bit
  localparam int M_POP  = 2;  // pop coinciding with the last-bit push
  localparam int M_CLR  = 3;  // overflow clear coinciding with the last-bit push

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          s_sck, s_mosi, s_ss, s_miso;
  logic [7:0]    rx_data, tx_data;
  logic          rx_valid, rx_ready, rx_overflow, rx_overflow_clr;
  logic [CW-1:0] rx_count;
  logic          tx_load, tx_ready, frame_active, frame_err, dbg_state;

  spi_slave_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .FAB_CCC_GL0     (clk),
    .FAB_RESET       (rst),
    .s_sck           (s_sck),
    .s_mosi          (s_mosi),
    .s_ss            (s_ss),
    .s_miso          (s_miso),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .rx_count        (rx_count),
    .rx_overflow     (rx_overflow),
    .rx_overflow_clr (rx_overflow_clr),
    .tx_data         (tx_data),
    .tx_load         (tx_load),
    .tx_ready        (tx_ready),
    .frame_active    (frame_active),
    .frame_err       (frame_err),
    .dbg_state       (dbg_state)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] mosi;
    logic       load;
    logic [7:0] tx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic load_tx(input logic [7:0] b);
    tx_data = b;
    tx_load = 1'b1;
    tick();
    tx_load = 1'b0;
  endtask

  task automatic ss_low();
    s_ss = 1'b0;
    repeat (HALF) tick();
  endtask

  task automatic ss_high();
    s_ss = 1'b1;
    repeat (2*HALF) tick();
  endtask

  task automatic spi_xfer(input logic [7:0] mosi_b, input int nbits, input bit exp_push,
                          input int mode, output logic [7:0] miso_b);
    miso_b = 8'h00;
    if (exp_push) exp_q.push_back(mosi_b);
    for (int i = 0; i < nbits; i++) begin
      s_mosi = mosi_b[7-i];
      repeat (HALF) tick();
      miso_b[7-i] = s_miso;
      s_sck = 1'b1;
      for (int k = 0; k < HALF; k++) begin
        if (i == 7 && k == SYNC) begin
          // sck_rise strobe cycle for the last bit; push lands on the next edge
          if (mode == M_LAT) check("lat_pre_valid", rx_valid, 0);
          if (mode == M_POP) begin
            check("pop_full_count", rx_count, DEPTH);
            check("pop_head", rx_data, exp_q[0]);
            exp_q.delete(0);
            rx_ready = 1'b1;
          end
          if (mode == M_CLR) rx_overflow_clr = 1'b1;
        end
        if (i == 7 && k == SYNC + 1) begin
          if (mode == M_LAT) begin
            check("lat_valid", rx_valid, 1);
            check("lat_data", rx_data, mosi_b);
          end
          if (mode == M_POP) begin
            rx_ready = 1'b0;
            check("pop_push_count", rx_count, DEPTH);
            check("pop_push_ovf", rx_overflow, 0);
          end
          if (mode == M_CLR) begin
            rx_overflow_clr = 1'b0;
            check("clr_vs_set_ovf", rx_overflow, 1);
          end
        end
        tick();
      end
      s_sck = 1'b0;
    end
  endtask

  // pops everything in the scoreboard back to back, one per cycle
  task automatic drain();
    int n;
    n = exp_q.size();
    rx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check("drain_count", rx_count, n - i);
      check("drain_data", rx_data, exp_q.pop_front());
      tick();
    end
    rx_ready = 1'b0;
    check("drain_empty", rx_valid, 0);
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: test did not complete");
    summary();
    $finish;
  end

  initial begin
    logic [7:0] m, m1, m2;
    int pulses;

    rst = 1'b1; s_sck = 1'b0; s_mosi = 1'b0; s_ss = 1'b1;
    rx_ready = 1'b0; rx_overflow_clr = 1'b0; tx_data = 8'h00; tx_load = 1'b0;

    vecs[0] = '{8'hA5, 1'b1, 8'h3C, 8'h3C};
    vecs[1] = '{8'h00, 1'b0, 8'h00, 8'hFF};
    vecs[2] = '{8'hFF, 1'b1, 8'h00, 8'h00};
    vecs[3] = '{8'h5A, 1'b1, 8'h81, 8'h81};
    vecs[4] = '{8'h80, 1'b1, 8'h01, 8'h01};
    vecs[5].mosi = 8'($urandom_range(0, 255));
    vecs[5].load = 1'b1;
    vecs[5].tx   = 8'($urandom_range(0, 255));
    vecs[5].exp_miso = vecs[5].tx;
    vecs[6].mosi = 8'($urandom_range(0, 255));
    vecs[6].load = 1'b0;
    vecs[6].tx   = 8'($urandom_range(0, 255));
    vecs[6].exp_miso = 8'hFF;

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset values
    check("rst_miso", s_miso, 1);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_count", rx_count, 0);
    check("rst_ovf", rx_overflow, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_frame_active", frame_active, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_state", dbg_state, 0);
    repeat (5) tick();

    // table-driven single-byte frames
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].load) begin
        load_tx(vecs[v].tx);
        check("vec_tx_pending", tx_ready, 0);
      end
      ss_low();
      check("vec_frame_active", frame_active, 1);
      check("vec_state", dbg_state, 1);
      spi_xfer(vecs[v].mosi, 8, 1'b1, M_LAT, m);
      ss_high();
      check("vec_miso", m, vecs[v].exp_miso);
      check("vec_tx_ready", tx_ready, 1);
      check("vec_frame_idle", frame_active, 0);
      drain();
    end

    // burst without tx data
    ss_low();
    spi_xfer(8'h01, 8, 1'b1, M_NONE, m);
    check("burst_miso0", m, 8'hFF);
    spi_xfer(8'h02, 8, 1'b1, M_NONE, m);
    check("burst_miso1", m, 8'hFF);
    spi_xfer(8'h03, 8, 1'b1, M_NONE, m);
    check("burst_miso2", m, 8'hFF);
    ss_high();
    check("burst_count", rx_count, 3);
    drain();

    // overflow: 9 bytes, no pops
    ss_low();
    for (int b = 0; b < DEPTH; b++) spi_xfer(8'(8'h10 + b), 8, 1'b1, M_NONE, m);
    check("pre_ovf_flag", rx_overflow, 0);
    spi_xfer(8'hEE, 8, 1'b0, M_NONE, m);
    ss_high();
    check("ovf_count", rx_count, DEPTH);
    check("ovf_flag", rx_overflow, 1);
    drain();
    check("ovf_sticky", rx_overflow, 1);
    rx_overflow_clr = 1'b1;
    tick();
    rx_overflow_clr = 1'b0;
    check("ovf_cleared", rx_overflow, 0);

    // 9th push with a coincident pop
    ss_low();
    for (int b = 0; b < DEPTH; b++) spi_xfer(8'(8'h20 + b), 8, 1'b1, M_NONE, m);
    spi_xfer(8'h29, 8, 1'b1, M_POP, m);
    ss_high();
    check("pop9_count", rx_count, DEPTH);
    check("pop9_ovf", rx_overflow, 0);
    drain();

    // overflow clear coinciding with an overflow push
    ss_low();
    for (int b = 0; b < DEPTH; b++) spi_xfer(8'(8'h30 + b), 8, 1'b1, M_NONE, m);
    spi_xfer(8'h3F, 8, 1'b0, M_CLR, m);
    ss_high();
    check("clr9_ovf", rx_overflow, 1);
    drain();
    rx_overflow_clr = 1'b1;
    tick();
    rx_overflow_clr = 1'b0;

    // abort after 5 bits
    ss_low();
    spi_xfer(8'hB7, 5, 1'b0, M_NONE, m);
    s_ss = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (frame_err) pulses++;
    end
    check("abort_err_pulses", pulses, 1);
    check("abort_count", rx_count, 0);
    check("abort_state", dbg_state, 0);
    load_tx(8'hC5);
    ss_low();
    spi_xfer(8'h5A, 8, 1'b1, M_LAT, m);
    ss_high();
    check("after_abort_miso", m, 8'hC5);
    drain();

    // tx_load while pending keeps the original byte
    load_tx(8'h11);
    check("pend_ready0", tx_ready, 0);
    load_tx(8'h22);
    check("pend_ready1", tx_ready, 0);
    ss_low();
    check("pend_consumed", tx_ready, 1);
    spi_xfer(8'h3E, 8, 1'b1, M_NONE, m1);
    spi_xfer(8'h4D, 8, 1'b1, M_NONE, m2);
    ss_high();
    check("pend_miso0", m1, 8'h11);
    check("pend_miso1", m2, 8'hFF);
    drain();

    // reset mid-frame after 4 bits
    ss_low();
    spi_xfer(8'h99, 8, 1'b1, M_NONE, m);
    ss_high();
    load_tx(8'h77);
    ss_low();
    spi_xfer(8'hF0, 4, 1'b0, M_NONE, m);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
    check("mid_rst_miso", s_miso, 1);
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_count", rx_count, 0);
    check("mid_rst_ovf", rx_overflow, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_frame_active", frame_active, 0);
    check("mid_rst_frame_err", frame_err, 0);
    check("mid_rst_state", dbg_state, 0);
    // SS still low: remaining bits and a whole byte must be ignored
    spi_xfer(8'h0F, 4, 1'b0, M_NONE, m);
    spi_xfer(8'h6B, 8, 1'b0, M_NONE, m);
    check("held_ss_miso", m, 8'hFF);
    check("held_ss_count", rx_count, 0);
    check("held_ss_frame", frame_active, 0);
    ss_high();
    ss_low();
    check("fresh_frame", frame_active, 1);
    spi_xfer(8'hC3, 8, 1'b1, M_NONE, m);
    ss_high();
    check("fresh_miso", m, 8'hFF);
    drain();

    summary();
    $finish;
  end

endmodule
